// File: rtl/dec_entry_to_bin_pkg.sv
// Shared types and constants for the decimal-entry front end.
// Holds the FSM state enum and reverse double-dabble constants.
package dec_entry_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_e;

  localparam logic [3:0] DIGIT_MAX  = 4'd9;
  localparam logic [3:0] SUB_THRESH = 4'd8;
  localparam logic [3:0] SUB_VAL    = 4'd3;

endpackage

// File: rtl/dec_entry_to_bin_if.sv
// Keypad-side bus of dec_entry_to_bin: digit/enter/clear in,
// status and binary result out. del_in exists with DEC_ENTRY_BACKSPACE_EN.
interface dec_entry_to_bin_if #(
  parameter int N_DIGITS = 4,
  parameter int N_OUT    = 14
);
  localparam int CW = $clog2(N_DIGITS + 1);

`ifdef DEC_ENTRY_BACKSPACE_EN
  logic             del_in;
`endif
  logic [3:0]       digit_in;
  logic             digit_valid;
  logic             enter;
  logic             clear;
  logic             ready;
  logic [CW-1:0]    digit_cnt;
  logic             full;
  logic             err;
  logic [N_OUT-1:0] bin_out;
  logic             bin_valid;

  modport master (
`ifdef DEC_ENTRY_BACKSPACE_EN
    output del_in,
`endif
    output digit_in, digit_valid, enter, clear,
    input  ready, digit_cnt, full, err,
    input  bin_out, bin_valid
  );

  modport slave (
`ifdef DEC_ENTRY_BACKSPACE_EN
    input  del_in,
`endif
    input  digit_in, digit_valid, enter, clear,
    output ready, digit_cnt, full, err,
    output bin_out, bin_valid
  );

endinterface

// File: rtl/dec_entry_to_bin_sub3.sv
// bcd_sub3_nibble: one reverse double-dabble correction step.
// nib_i (4b) -> nib_o (4b): subtract 3 when nib_i >= 8.
module bcd_sub3_nibble
  import dec_entry_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  assign nib_o = (nib_i >= SUB_THRESH) ? nib_i - SUB_VAL : nib_i;

endmodule

// File: rtl/dec_entry_to_bin.sv
// Decimal digit entry into a BCD register, converted to binary on enter
// by iterative reverse double-dabble. Ports: clk, rst_n, bus (slave).
// Macro DEC_ENTRY_BACKSPACE_EN adds a del_in backspace.
module dec_entry_to_bin
  import dec_entry_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int N_OUT    = 14
) (
  input logic               clk,
  input logic               rst_n,
  dec_entry_to_bin_if.slave bus
);

  localparam int BW = 4 * N_DIGITS;
  localparam int CW = $clog2(N_DIGITS + 1);
  localparam int IW = $clog2(N_OUT);

  state_e           state_q, state_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [N_OUT-1:0] bin_q, bin_d;
  logic [N_OUT-1:0] bin_out_q, bin_out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    iter_q, iter_d;
  logic             err_q, err_d;

  logic             full;
  logic [BW-1:0]    bcd_sh, bcd_adj;
  logic [N_OUT-1:0] bin_sh;

  assign full = (cnt_q == CW'(N_DIGITS));

  // The BCD entry register doubles as the conversion register:
  // bcd LSB falls into bin MSB each iteration.
  assign {bcd_sh, bin_sh} = {bcd_q, bin_q} >> 1;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_nib
    bcd_sub3_nibble u_sub3 (
      .nib_i (bcd_sh[4*g +: 4]),
      .nib_o (bcd_adj[4*g +: 4])
    );
  end

  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    bin_out_d = bin_out_q;
    cnt_d     = cnt_q;
    iter_d    = iter_q;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.clear) begin
          bcd_d = '0;
          cnt_d = '0;
        end else if (bus.enter) begin
          bin_d   = '0;
          iter_d  = '0;
          state_d = CONV;
`ifdef DEC_ENTRY_BACKSPACE_EN
        end else if (bus.del_in) begin
          if (cnt_q != '0) begin
            bcd_d = bcd_q >> 4;
            cnt_d = cnt_q - 1'b1;
          end
`endif
        end else if (bus.digit_valid) begin
          if (bus.digit_in > DIGIT_MAX || full) begin
            err_d = 1'b1;
          end else begin
            bcd_d = {bcd_q[BW-5:0], bus.digit_in};
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      CONV: begin
        bcd_d  = bcd_adj;
        bin_d  = bin_sh;
        iter_d = iter_q + 1'b1;
        if (iter_q == IW'(N_OUT - 1)) begin
          // Publish the result as we enter DONE so it
          // lines up with bin_valid.
          bin_out_d = bin_sh;
          state_d   = DONE;
        end
      end
      DONE: begin
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bcd_q     <= '0;
      bin_q     <= '0;
      bin_out_q <= '0;
      cnt_q     <= '0;
      iter_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      bin_out_q <= bin_out_d;
      cnt_q     <= cnt_d;
      iter_q    <= iter_d;
      err_q     <= err_d;
    end
  end

  assign bus.ready     = (state_q == IDLE);
  assign bus.digit_cnt = cnt_q;
  assign bus.full      = full;
  assign bus.err       = err_q;
  assign bus.bin_out   = bin_out_q;
  assign bus.bin_valid = (state_q == DONE);

endmodule

// File: tb/tb_dec_entry_to_bin.sv
// Scoreboard bench for dec_entry_to_bin: expected results queued
// on enter, popped when bin_valid pulses.
module tb_dec_entry_to_bin;

  localparam int ND = 4;
  localparam int NO = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dec_entry_to_bin_if #(.N_DIGITS(ND), .N_OUT(NO)) bus ();

  dec_entry_to_bin #(.N_DIGITS(ND), .N_OUT(NO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  int exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.bin_valid) begin
      if (exp_q.size() == 0) chk("spurious_valid", 1, 0);
      else chk("bin_out", 32'(bus.bin_out), exp_q.pop_front());
    end
  end

  task automatic send_digit(input logic [3:0] d, input logic e);
    bus.digit_in    = d;
    bus.digit_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.digit_valid = 1'b0;
    chk("err", bus.err, e);
    if (e) begin
      @(posedge clk);
      #1;
      chk("err_pulse_end", bus.err, 0);
    end
  endtask

  task automatic do_enter(input int expv);
    logic busy_ok;
    logic seen;
    busy_ok   = 1'b1;
    seen      = 1'b0;
    bus.enter = 1'b1;
    @(posedge clk);
    exp_q.push_back(expv);
    #1;
    bus.enter = 1'b0;
    for (int j = 1; j <= 40 && !seen; j++) begin
      @(negedge clk);
      if (bus.bin_valid) begin
        seen = 1'b1;
        chk("latency", j, 15);
      end else if (bus.ready) begin
        busy_ok = 1'b0;
      end
    end
    chk("ready_low", busy_ok, 1);
    if (!seen) begin
      chk("timeout", 0, 1);
      exp_q.delete();
    end else begin
      @(negedge clk);
      chk("ready_back", bus.ready, 1);
      chk("cnt_cleared", 32'(bus.digit_cnt), 0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int v;
    int d;
`ifdef DEC_ENTRY_BACKSPACE_EN
    bus.del_in = 1'b0;
`endif
    bus.digit_in    = '0;
    bus.digit_valid = 1'b0;
    bus.enter       = 1'b0;
    bus.clear       = 1'b0;

    #3;
    chk("rst_bin_out", 32'(bus.bin_out), 0);
    chk("rst_cnt", 32'(bus.digit_cnt), 0);
    chk("rst_valid", bus.bin_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready", bus.ready, 1);
    chk("rst_err", bus.err, 0);

    // 1234
    send_digit(4'd1, 1'b0);
    send_digit(4'd2, 1'b0);
    send_digit(4'd3, 1'b0);
    send_digit(4'd4, 1'b0);
    chk("cnt4", 32'(bus.digit_cnt), 4);
    do_enter(1234);

    // 9999 and overflow digit
    repeat (4) send_digit(4'd9, 1'b0);
    chk("full", bus.full, 1);
    send_digit(4'd5, 1'b1);
    chk("cnt_full", 32'(bus.digit_cnt), 4);
    do_enter(9999);

    // invalid digit then 42
    send_digit(4'hB, 1'b1);
    chk("cnt_bad_digit", 32'(bus.digit_cnt), 0);
    send_digit(4'd4, 1'b0);
    send_digit(4'd2, 1'b0);
    chk("cnt2", 32'(bus.digit_cnt), 2);
    chk("not_full", bus.full, 0);
    do_enter(42);

    // reset in the middle of converting 5678
    send_digit(4'd5, 1'b0);
    send_digit(4'd6, 1'b0);
    send_digit(4'd7, 1'b0);
    send_digit(4'd8, 1'b0);
    bus.enter = 1'b1;
    @(posedge clk);
    #1;
    bus.enter = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bin_out", 32'(bus.bin_out), 0);
    chk("mid_rst_cnt", 32'(bus.digit_cnt), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", bus.ready, 1);
    repeat (20) @(negedge clk);
    chk("mid_rst_hold", 32'(bus.bin_out), 0);
    @(posedge clk);
    #1;

    // clear wins over a simultaneous digit
    send_digit(4'd3, 1'b0);
    bus.clear       = 1'b1;
    bus.digit_in    = 4'd7;
    bus.digit_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.clear       = 1'b0;
    bus.digit_valid = 1'b0;
    chk("clear_cnt", 32'(bus.digit_cnt), 0);
    chk("clear_err", bus.err, 0);
    do_enter(0);

    // random entries
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, ND);
      v = 0;
      for (int i = 0; i < n; i++) begin
        d = $urandom_range(0, 9);
        send_digit(4'(d), 1'b0);
        v = v * 10 + d;
      end
      do_enter(v);
    end
    do_enter(0);

`ifdef DEC_ENTRY_BACKSPACE_EN
    send_digit(4'd8, 1'b0);
    send_digit(4'd1, 1'b0);
    send_digit(4'd3, 1'b0);
    bus.del_in = 1'b1;
    @(posedge clk);
    #1;
    bus.del_in = 1'b0;
    chk("del_cnt", 32'(bus.digit_cnt), 2);
    send_digit(4'd6, 1'b0);
    do_enter(816);
    bus.del_in = 1'b1;
    @(posedge clk);
    #1;
    bus.del_in = 1'b0;
    chk("del_empty_cnt", 32'(bus.digit_cnt), 0);
    chk("del_empty_err", bus.err, 0);
    do_enter(0);
`endif

    repeat (3) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dec_entry_to_bin.md
Name: dec_entry_to_bin

Overview:
- Sequential decimal-entry front end; the input-side counterpart of the binary-to-BCD 7-segment display path.
- Accepts decimal digits one at a time, most significant first, from a keypad/switch debouncer into a BCD shift register.
- On "enter", converts the stored BCD value to binary with an iterative reverse double-dabble (shift-right / subtract-3).
- The resulting binary value feeds the datapath or loops back to the display path.

Parameters:
- N_DIGITS, 4, number of BCD digits stored (BCD register width 4*N_DIGITS).
- N_OUT, 14, binary result width; must satisfy 10^N_DIGITS-1 < 2^N_OUT; also equals the conversion iteration count.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- digit_in  input  4  decimal digit, 0..9.
- digit_valid  input  1  digit_in is offered this cycle.
- enter  input  1  start conversion of stored digits.
- clear  input  1  discard stored digits.
- ready  output  1  block is in IDLE and accepts digit/enter/clear.
- digit_cnt  output  $clog2(N_DIGITS+1)  number of digits stored.
- full  output  1  digit_cnt == N_DIGITS.
- err  output  1  one-cycle pulse: digit_in > 9 was offered, or a digit was offered while full.
- bin_out  output  N_OUT  last conversion result; held until the next conversion completes.
- bin_valid  output  1  one-cycle pulse when bin_out updates.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE; BCD register, binary shift register, bin_out and digit_cnt = 0.
  - err = 0, bin_valid = 0, ready = 1 after release.
- States: IDLE, CONV, DONE. ready = (state == IDLE).
- IDLE, priority: clear > enter > digit_valid.
  - clear: BCD register = 0, digit_cnt = 0; any simultaneous enter or digit is ignored.
  - enter: copy the BCD register into the conversion register; binary shift register = 0; iteration counter = 0; go to CONV. A simultaneous digit is dropped with no err.
  - digit_valid with digit_in <= 9 and not full: BCD reg = {BCD reg[4*N_DIGITS-5:0], digit_in}; digit_cnt increments.
  - digit_valid with digit_in > 9, or while full: register unchanged; err pulses on the next cycle.
- CONV, one iteration per cycle, N_OUT iterations:
  - Shift {bcd, bin} right by one bit; the bcd LSB enters the bin MSB.
  - Then, for every BCD nibble whose post-shift value is >= 8, subtract 3 from that nibble.
  - After iteration N_OUT-1, go to DONE.
  - Inputs are ignored during CONV and DONE (ready = 0).
- DONE (one cycle):
  - bin_out = bin register; bin_valid = 1.
  - BCD register and digit_cnt cleared, so a new entry starts.
  - Return to IDLE.
- Latency: enter sampled at edge k → bin_valid high in cycle k+N_OUT+1 (15 cycles at the defaults). ready returns in the cycle after bin_valid.
- enter with digit_cnt == 0 converts 0: bin_out = 0 and bin_valid still pulses.
- Values with leading digits not entered are right-aligned, so "4","2" = 42.
- Reset mid-CONV aborts the conversion; bin_out returns to 0.

Optional Feature:
- Macro: DEC_ENTRY_BACKSPACE_EN.
- Defined:
  - Adds input del_in (1 bit).
  - In IDLE, priority is clear > enter > del_in > digit_valid.
  - del_in with digit_cnt > 0: BCD register shifts right by 4 (zero-filled MSB nibble); digit_cnt decrements.
  - del_in with digit_cnt == 0: no effect, no err.
- Undefined: port absent, no backspace logic.

Decomposition:
- Package dec_entry_pkg:
  - state enum {IDLE, CONV, DONE}.
  - Constants: DIGIT_MAX = 4'd9, SUB_THRESH = 4'd8, SUB_VAL = 4'd3.
- Sub-module bcd_sub3_nibble: combinational; 4-bit in → 4-bit out; subtracts 3 when the input is >= 8.
  - Instantiated N_DIGITS times in a generate loop inside the CONV datapath.

Test Plan:
- Reset, digits 1,2,3,4, enter → bin_out = 1234 (0x4D2); bin_valid exactly 15 cycles after enter; ready=0 throughout; digit_cnt = 0 afterwards.
- Digits 9,9,9,9, then 5 → full=1, err pulses once, 5 dropped; enter → bin_out = 9999 (0x270F).
- Digit 0xB → err pulse, digit_cnt unchanged; then digits 4,2, enter → bin_out = 42.
- enter with no digits → bin_out = 0, bin_valid pulses; clear and digit 7 in the same cycle → digit_cnt = 0, BCD register = 0.
- Start conversion of 5678, assert rst_n low at iteration 6 → bin_out = 0, state IDLE, ready = 1 after release, no bin_valid.
- With DEC_ENTRY_BACKSPACE_EN: digits 8,1,3, del_in, 6, enter → bin_out = 816; del_in at digit_cnt = 0 → no change, no err.
